// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the clock-enable sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_seq_pkg;

   // Sequencer FSM encoding, kept as plain constants for legacy tools.
   typedef logic [1:0] state_t;
   localparam state_t SETTLE = 2'd0;
   localparam state_t RUN    = 2'd1;
   localparam state_t DRAIN  = 2'd2;

   // Channel select encoding on cfg_sel.
   localparam logic CH_PIX = 1'b0;
   localparam logic CH_SYS = 1'b1;

   // Result of a divide-ratio clamp: the usable ratio and whether it was altered.
   typedef struct packed {
      logic        clamped;
      logic [31:0] div;
   } clamp_t;

   // Ratios of 0 and 1 cannot make a square clock, so they are raised to 2.
   function automatic clamp_t clamp_div(input logic [31:0] div_in);
      clamp_t r;
      r.clamped = (div_in < 32'd2);
      r.div     = r.clamped ? 32'd2 : div_in;
      return r;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided clock channel: wrap counter, ratio register, ce pulse and square level.
// Latency: ce/clk_lvl decode combinationally from the registered counter; a load takes effect on the wrap edge.
// Backpressure: none; a load request is only honoured on the ce cycle, otherwise ignored.
module clk_div_chan #(
   parameter int DIV_W   = 8,
   parameter int DIV_RST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_vld,
   input  logic [DIV_W-1:0] load_div,
   output logic             ce,
   output logic             clk_lvl
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;

   // Decode enable pulse and square level from registered state only.
   always_comb begin
      ce      = (cnt_q == (div_q - DIV_W'(1)));
      clk_lvl = (cnt_q >= (div_q >> 1));
   end

   // Count 0..div-1; a new ratio is swapped in exactly as the counter wraps.
   always_comb begin
      cnt_d = ce ? '0 : (cnt_q + DIV_W'(1));
      div_d = (load_vld && ce) ? load_div : div_q;
   end

   // Counter and ratio registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         div_q <= DIV_W'(DIV_RST);
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/clk_en_sequencer.sv
// Pixel/system clock-enable generator with run-time ratio changes behind a config handshake.
// Latency: accept -> load on the selected channel's next wrap -> SETTLE_CYCLES -> clks_valid.
// Backpressure: cfg_ready is high only in RUN; cfg_valid at other times is ignored and must be held.
module clk_en_sequencer
   import clk_seq_pkg::*;
#(
   parameter int DIV_W         = 8,
   parameter int PIX_DIV_RST   = 4,
   parameter int SYS_DIV_RST   = 2,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic             CLKIN_100700kHz,
   input  logic             rst_n,
   input  logic             cfg_valid,
   input  logic             cfg_sel,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_clamped,
   output logic             pix_ce,
   output logic             pix_clk,
   output logic             sys_ce,
   output logic             sys_clk,
   output logic             clks_valid
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t           state_q, state_d;
   logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic             pend_sel_q, pend_sel_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             clamped_q, clamped_d;
   logic             pix_load, sys_load;
   logic             sel_ce;
   clamp_t           clamp_res;
   logic             unused_clamp_hi;

   clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(PIX_DIV_RST)) u_pix (
      .clk      (CLKIN_100700kHz),
      .rst_n    (rst_n),
      .load_vld (pix_load),
      .load_div (pend_div_q),
      .ce       (pix_ce),
      .clk_lvl  (pix_clk)
   );

   clk_div_chan #(.DIV_W(DIV_W), .DIV_RST(SYS_DIV_RST)) u_sys (
      .clk      (CLKIN_100700kHz),
      .rst_n    (rst_n),
      .load_vld (sys_load),
      .load_div (pend_div_q),
      .ce       (sys_ce),
      .clk_lvl  (sys_clk)
   );

   // Clamp the incoming ratio; upper bits of the helper result are always zero.
   always_comb begin
      clamp_res       = clamp_div(32'(cfg_div));
      unused_clamp_hi = ^clamp_res.div[31:DIV_W];
      sel_ce          = (pend_sel_q == CH_SYS) ? sys_ce : pix_ce;
   end

   // Sequencer: settle timer, single-entry request capture, and load on the selected wrap.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      pend_sel_d   = pend_sel_q;
      pend_div_d   = pend_div_q;
      clamped_d    = 1'b0;
      pix_load     = 1'b0;
      sys_load     = 1'b0;
      cfg_ready    = (state_q == RUN);
      clks_valid   = (state_q == RUN);
      case (state_q)
         SETTLE: begin
            if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
               state_d      = RUN;
               settle_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + SC_W'(1);
            end
         end
         RUN: begin
            if (cfg_valid) begin
               pend_sel_d = cfg_sel;
               pend_div_d = clamp_res.div[DIV_W-1:0];
               clamped_d  = clamp_res.clamped;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            // Only ce cycles seen while already in DRAIN count, so the
            // acceptance edge itself can never trigger the load.
            if (sel_ce) begin
               pix_load     = (pend_sel_q == CH_PIX);
               sys_load     = (pend_sel_q == CH_SYS);
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end
         end
         default: begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
         end
      endcase
   end

   assign cfg_clamped = clamped_q;

   // Sequencer state registers; reset discards any pending request.
   always_ff @(posedge CLKIN_100700kHz) begin
      if (!rst_n) begin
         state_q      <= SETTLE;
         settle_cnt_q <= '0;
         pend_sel_q   <= CH_PIX;
         pend_div_q   <= '0;
         clamped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         pend_sel_q   <= pend_sel_d;
         pend_div_q   <= pend_div_d;
         clamped_q    <= clamped_d;
      end
   end

endmodule
